// File: rtl/instr_pkg.sv
// Shared opcode, immediate-type and FSM definitions for the RV32I instruction encoder.
package instr_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // I..J match the decoder; R has no immediate, BAD marks an unknown opcode
    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_U   = 3'b011;
    localparam logic [2:0] IMM_J   = 3'b100;
    localparam logic [2:0] IMM_R   = 3'b101;
    localparam logic [2:0] IMM_BAD = 3'b111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fields_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Job control, field-bundle stream and memory write port of the instruction encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_instr;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  err_count;

    modport master (
        output start, base_addr, num_instr, in_valid, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_count
    );

    modport slave (
        input  start, base_addr, num_instr, in_valid, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_count
    );

endinterface

// File: rtl/instr_pack.sv
// Combinational RV32I field packer. Unknown opcodes report imm_type IMM_BAD and pack a NOP;
// o_err flags immediates that do not fit (only when INSTR_ENC_RANGE_CHECK_EN is defined).
module instr_pack
    import instr_pkg::*;
(
    input  fields_t     i_f,
    output logic [31:0] o_word,
    output logic [2:0]  o_imm_type,
    output logic        o_err
);

    logic w_rng_bad;

    always_comb begin
        o_word     = NOP;
        o_imm_type = IMM_BAD;
        case (i_f.opcode)
            OP_R: begin
                o_word     = {i_f.funct7, i_f.rs2, i_f.rs1, i_f.funct3, i_f.rd, i_f.opcode};
                o_imm_type = IMM_R;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                o_word     = {i_f.imm[11:0], i_f.rs1, i_f.funct3, i_f.rd, i_f.opcode};
                o_imm_type = IMM_I;
            end
            OP_STORE: begin
                o_word     = {i_f.imm[11:5], i_f.rs2, i_f.rs1, i_f.funct3, i_f.imm[4:0], i_f.opcode};
                o_imm_type = IMM_S;
            end
            OP_BRANCH: begin
                o_word     = {i_f.imm[12], i_f.imm[10:5], i_f.rs2, i_f.rs1, i_f.funct3,
                              i_f.imm[4:1], i_f.imm[11], i_f.opcode};
                o_imm_type = IMM_B;
            end
            OP_LUI, OP_AUIPC: begin
                o_word     = {i_f.imm[31:12], i_f.rd, i_f.opcode};
                o_imm_type = IMM_U;
            end
            OP_JAL: begin
                o_word     = {i_f.imm[20], i_f.imm[10:1], i_f.imm[11], i_f.imm[19:12], i_f.rd, i_f.opcode};
                o_imm_type = IMM_J;
            end
            default: ;
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    // An immediate fits when every bit above the field's sign bit replicates it
    always_comb begin
        w_rng_bad = 1'b0;
        case (o_imm_type)
            IMM_I, IMM_S: w_rng_bad = (i_f.imm[31:11] != {21{i_f.imm[11]}});
            IMM_B:        w_rng_bad = (i_f.imm[31:12] != {20{i_f.imm[12]}}) || i_f.imm[0];
            IMM_J:        w_rng_bad = (i_f.imm[31:20] != {12{i_f.imm[20]}}) || i_f.imm[0];
            IMM_U:        w_rng_bad = (i_f.imm[11:0] != 12'h000);
            default:      w_rng_bad = 1'b0;
        endcase
    end
`else
    assign w_rng_bad = 1'b0;
`endif

    assign o_err = w_rng_bad;

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder top: job FSM, address/count tracking and one output register stage
// feeding instruction memory. Optional immediate range checking: INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    instr_encoder_if.slave  bus
);

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_remain;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic              r_err;
    logic [CNT_W-1:0]  r_err_cnt;

    fields_t           w_fields;
    logic [31:0]       w_word;
    logic [2:0]        w_type;
    logic              w_rng_err;
    logic              w_err;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_wr_done;
    logic              w_start;

    assign w_fields = '{opcode: bus.in_opcode, funct3: bus.in_funct3, funct7: bus.in_funct7,
                        rd: bus.in_rd, rs1: bus.in_rs1, rs2: bus.in_rs2, imm: bus.in_imm};

    instr_pack u_pack (
        .i_f        (w_fields),
        .o_word     (w_word),
        .o_imm_type (w_type),
        .o_err      (w_rng_err)
    );

    assign w_err      = w_rng_err || (w_type == IMM_BAD);
    assign w_start    = (r_state == ST_IDLE) && bus.start;
    assign w_wr_done  = r_we && bus.mem_ready;
    // Ready while the output register is empty or being drained this cycle: no bubble
    assign w_in_ready = (r_state == ST_RUN) && (r_remain != '0) && (!r_we || bus.mem_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_next = (bus.num_instr == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (w_accept && (r_remain == CNT_W'(1))) w_next = ST_DRAIN;
            ST_DRAIN: if (!r_we || bus.mem_ready) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remain  <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_start) begin
                r_err     <= 1'b0;
                r_err_cnt <= '0;
                if (bus.num_instr != '0) begin
                    r_addr   <= {bus.base_addr[ADDR_W-1:2], 2'b00};
                    r_remain <= bus.num_instr;
                end
            end
            // No writes are in flight in IDLE, so this never collides with the base load
            if (w_wr_done) r_addr <= r_addr + ADDR_W'(4);
            if (w_accept) begin
                r_wdata  <= w_word;
                r_remain <= r_remain - CNT_W'(1);
                if (w_err) begin
                    r_err     <= 1'b1;
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
            end
            if (w_accept)       r_we <= 1'b1;
            else if (w_wr_done) r_we <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.err       = r_err;
    assign bus.err_count = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table of hand-encoded instructions, write scoreboard,
// and directed sequences for stall, error, wrap, empty-job and mid-job reset.
module tb_instr_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_encoder_if #(.ADDR_W(32), .CNT_W(16)) bus ();
    instr_encoder #(.ADDR_W(32), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t   exp_q[$];
    int    wr_cyc[$];
    int    nvec = 0;
    int    nmis = 0;
    vec_t  tbl[8];
    vec_t  v_addi, v_lui, v_unk, v_big;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every completed write handshake must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && bus.mem_we && bus.mem_ready) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", bus.mem_addr, 32'hxxxx_xxxx);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", bus.mem_addr, e.addr);
                chk("wr_data", bus.mem_wdata, e.data);
            end
        end
    end

    task automatic start_job(input logic [31:0] base, input logic [15:0] num);
        bus.base_addr = base;
        bus.num_instr = num;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
    endtask

    task automatic drive_fields(input vec_t v);
        bus.in_opcode = v.op;
        bus.in_funct3 = v.f3;
        bus.in_funct7 = v.f7;
        bus.in_rd     = v.rd;
        bus.in_rs1    = v.rs1;
        bus.in_rs2    = v.rs2;
        bus.in_imm    = v.imm;
    endtask

    task automatic send(input vec_t v, input logic [31:0] addr);
        bit ok = 0;
        drive_fields(v);
        bus.in_valid = 1'b1;
        exp_q.push_back('{addr: addr, data: v.word});
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            void'(exp_q.pop_back());
            chk("in_ready_timeout", 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) begin ok = 1; break; end
        end
        chk("done_seen", 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int nw;
        tbl[0] = '{7'h23, 3'd2, 7'h00, 5'd31, 5'd1, 5'd2, 32'h0000_0008, 32'h0020_A423}; // sw x2,8(x1)
        tbl[1] = '{7'h63, 3'd0, 7'h00, 5'd7,  5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3}; // beq x0,x0,-4
        tbl[2] = '{7'h6F, 3'd0, 7'h00, 5'd1,  5'd3, 5'd0, 32'h0000_0800, 32'h0010_00EF}; // jal x1,2048
        tbl[3] = '{7'h33, 3'd0, 7'h00, 5'd3,  5'd1, 5'd2, 32'hDEAD_BEEF, 32'h0020_81B3}; // add x3,x1,x2
        tbl[4] = '{7'h33, 3'd0, 7'h20, 5'd3,  5'd1, 5'd2, 32'h0000_0000, 32'h4020_81B3}; // sub x3,x1,x2
        tbl[5] = '{7'h03, 3'd2, 7'h00, 5'd4,  5'd5, 5'd0, 32'hFFFF_FFFF, 32'hFFF2_A203}; // lw x4,-1(x5)
        tbl[6] = '{7'h67, 3'd0, 7'h00, 5'd0,  5'd1, 5'd0, 32'h0000_0000, 32'h0000_8067}; // jalr x0,0(x1)
        tbl[7] = '{7'h17, 3'd0, 7'h00, 5'd10, 5'd0, 5'd0, 32'h0000_1000, 32'h0000_1517}; // auipc x10,1
        v_addi = '{7'h13, 3'd0, 7'h00, 5'd1,  5'd0, 5'd0, 32'h0000_0005, 32'h0050_0093};
        v_lui  = '{7'h37, 3'd0, 7'h00, 5'd5,  5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7};
        v_unk  = '{7'h7F, 3'd0, 7'h00, 5'd1,  5'd2, 5'd3, 32'h0000_0001, 32'h0000_0013};
        v_big  = '{7'h13, 3'd0, 7'h00, 5'd1,  5'd0, 5'd0, 32'h0000_0800, 32'h8000_0093};

        bus.start = 0; bus.base_addr = 0; bus.num_instr = 0; bus.in_valid = 0;
        bus.mem_ready = 1;
        drive_fields(v_addi);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
        rst = 0;
        @(posedge clk); #1;

        // Single addi
        start_job(32'h100, 16'd1);
        chk("busy_run", 32'(bus.busy), 32'd1);
        send(v_addi, 32'h100);
        wait_done();
        chk("job1_err", 32'(bus.err), 32'd0);
        chk("job1_busy_after", 32'(bus.busy), 32'd0);

        // Table streamed back-to-back; low address bits of base are dropped
        wr_cyc.delete();
        start_job(32'h103, 16'd8);
        for (int i = 0; i < 8; i++) send(tbl[i], 32'h100 + 32'(4 * i));
        wait_done();
        nw = wr_cyc.size();
        chk("stream_writes", 32'(nw), 32'd8);
        if (nw == 8) chk("stream_span", 32'(wr_cyc[7] - wr_cyc[0]), 32'd7);
        chk("stream_err", 32'(bus.err), 32'd0);

        // Memory back-pressure holds the word and the address
        bus.mem_ready = 0;
        start_job(32'h200, 16'd2);
        send(v_lui, 32'h200);
        drive_fields(v_addi);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_wdata", bus.mem_wdata, 32'h1234_52B7);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_addr", bus.mem_addr, 32'h200);
            chk("stall_we", 32'(bus.mem_we), 32'd1);
            @(posedge clk); #1;
        end
        bus.mem_ready = 1;
        send(v_addi, 32'h204);
        wait_done();

        // Unknown opcode and an oversized I immediate
        start_job(32'h300, 16'd2);
        send(v_unk, 32'h300);
        send(v_big, 32'h304);
        wait_done();
        chk("err_flag", 32'(bus.err), 32'd1);
`ifdef INSTR_ENC_RANGE_CHECK_EN
        chk("err_count", 32'(bus.err_count), 32'd2);
`else
        chk("err_count", 32'(bus.err_count), 32'd1);
`endif

        // Address wrap; the accepted start clears err
        start_job(32'hFFFF_FFFC, 16'd2);
        chk("err_cleared", 32'(bus.err), 32'd0);
        chk("err_count_cleared", 32'(bus.err_count), 32'd0);
        send(v_addi, 32'hFFFF_FFFC);
        send(v_lui, 32'h0000_0000);
        wait_done();

        // Empty job: done the cycle after start, no writes
        nw = wr_cyc.size();
        start_job(32'h500, 16'd0);
        @(negedge clk);
        chk("empty_done", 32'(bus.done), 32'd1);
        @(posedge clk); #1;
        chk("empty_done_drop", 32'(bus.done), 32'd0);
        chk("empty_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("empty_no_write", 32'(wr_cyc.size()), 32'(nw));

        // Start outside IDLE ignored, then reset mid-job with a write pending
        bus.mem_ready = 0;
        start_job(32'h600, 16'd3);
        send(v_addi, 32'h600);
        start_job(32'h900, 16'd1);
        chk("restart_ignored_addr", bus.mem_addr, 32'h600);
        #1;
        rst = 1;
        #1;
        chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_addr", bus.mem_addr, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 0;
        bus.mem_ready = 1;
        @(posedge clk); #1;
        start_job(32'h700, 16'd1);
        send(v_lui, 32'h700);
        wait_done();

        repeat (2) @(posedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decoder. Accepts decoded RV32I fields (opcode, funct3, funct7, rd, rs1, rs2, 32-bit imm) over a valid/ready stream.
- Packs the fields into canonical 32-bit instruction words and writes them into instruction memory at consecutive word addresses.
- Used by the program loader and self-test sequencer to build instruction images in hardware.
- Each job is started with a base address and an instruction count. The block reports completion and any encoding errors.

Parameters:
- ADDR_W, 32, width of the memory byte address.
- CNT_W, 16, width of the instruction count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a job; honoured only in IDLE.
- base_addr  input  ADDR_W  byte address of the first word; low 2 bits are ignored (forced to 0).
- num_instr  input  CNT_W  number of instructions in the job; 0 completes immediately.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  block accepts a bundle this cycle.
- in_opcode  input  7  opcode field.
- in_funct3  input  3  funct3 field.
- in_funct7  input  7  funct7 field.
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_imm  input  32  full, sign-extended immediate value (not the pre-shifted field).
- mem_we  output  1  write request.
- mem_addr  output  ADDR_W  word-aligned byte address.
- mem_wdata  output  32  encoded instruction.
- mem_ready  input  1  memory accepts the write when mem_we and mem_ready are both high.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a job completes.
- err  output  1  sticky encoding error; cleared by the next accepted start.
- err_count  output  CNT_W  number of bundles flagged with an error in the current job.

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, err_count=0, FSM=IDLE.
- FSM states:
  - IDLE: on start, if num_instr=0 go to DONE; otherwise latch the address and remaining count, clear err and err_count, go to RUN.
  - RUN: stream bundles. When the last bundle is accepted, go to DRAIN.
  - DRAIN: wait until the output register empties, then go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- start outside IDLE is ignored.
- Pipeline: a single output register stage. A bundle accepted at edge N appears on mem_* at edge N (mem_we=1 from cycle N+1).
- in_ready = (state==RUN) && remaining>0 && (!mem_we || mem_ready), so there is no bubble under continuous flow.
- mem_addr starts at base_addr and increments by 4 after each accepted write. It wraps modulo 2^ADDR_W without error.
- Format selection by opcode:
  - R (0110011): funct7|rs2|rs1|funct3|rd|op.
  - I (0010011, 0000011, 1100111): imm[11:0]|rs1|funct3|rd|op.
  - S (0100011): imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - B (1100011): imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - U (0110111, 0010111): imm[31:12]|rd|op.
  - J (1101111): imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Unused fields for a format are ignored.
- Unknown opcode: the word is written as 0x00000013 (NOP), err=1, err_count increments.
- Reset mid-job: FSM returns to IDLE immediately, any pending write is dropped, all outputs take their reset values.

Optional Feature:
- Macro INSTR_ENC_RANGE_CHECK_EN.
- Defined: flag an error when
  - I/S imm is not the sign-extension of imm[11:0];
  - B imm is outside the 13-bit signed range or imm[0]=1;
  - J imm is outside the 21-bit signed range or imm[0]=1;
  - U imm[11:0] is nonzero.
- On a flagged error: the word is still written with truncated fields, err=1, err_count increments.
- Undefined: truncation is silent. Only unknown opcodes raise err.

Decomposition:
- Package instr_pkg holds the opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR).
- It also holds the imm_type codes shared with the decoder: I=000, S=001, B=010, U=011, J=100.
- It also holds the FSM state enum and the NOP constant 0x00000013.
- Sub-module instr_pack (combinational): takes fields, returns {word, imm_type, err}. The top module holds the FSM, counters and output register.

Test Plan:
- start with base_addr=0x100 and num_instr=1, then send addi x1,x0,5 (op 0x13, rd=1, imm=5) -> one write at 0x100 with data 0x00500093, followed by a done pulse; err=0.
- Back-to-back bundles with mem_ready=1: sw x2,8(x1), then beq x0,x0,-4, then jal x1,2048 -> writes 0x0020A423@0x100, 0xFE000EE3@0x104, 0x001000EF@0x108 on consecutive cycles.
- lui x5 with imm=0x12345000 while mem_ready is held low for 3 cycles -> mem_wdata stays at 0x123452B7 and in_ready=0 until the handshake completes; the address does not advance until then.
- Unknown opcode 0x7F, plus (with INSTR_ENC_RANGE_CHECK_EN) addi with imm=2048 -> NOP written for the first bundle; err=1 and err_count=2.
- base_addr=0xFFFFFFFC with num_instr=2 -> writes at 0xFFFFFFFC then 0x00000000; num_instr=0 -> done one cycle after start with no writes.
- Assert rst during RUN with a write pending -> mem_we=0, busy=0, and in_ready=0 immediately; a subsequent start works normally.
